// File: rtl/return_address_stack.sv
// Speculative return address stack for fetch-stage return prediction.
// Define RAS_CHECKPOINT_EN to enable checkpointed pointer recovery on flush.
module return_address_stack #(
    parameter int DEPTH    = 8,
    parameter int MAX_SPEC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] new_addr,
    output logic [31:0] addr,
    output logic        valid,
    input  logic        branch_retired,
    input  logic        flush,
    output logic        spec_full
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   stack_r [DEPTH];
    logic [IW-1:0] read_index_r;
    logic [IW-1:0] read_index_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          wr_en_s;
    logic [IW-1:0] wr_idx_s;
    logic          restore_valid_s;
    logic [IW-1:0] restore_idx_s;
    logic [CW-1:0] restore_cnt_s;

    assign valid = (count_r != {CW{1'b0}});
    assign addr  = valid ? stack_r[read_index_r] : 32'h0000_0000;

`ifdef RAS_CHECKPOINT_EN
    localparam int SW = $clog2(MAX_SPEC);
    localparam int OW = $clog2(MAX_SPEC + 1);

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
    } ckpt_t;

    ckpt_t         ckpt_r [MAX_SPEC];
    logic [SW-1:0] head_r;
    logic [SW-1:0] tail_r;
    logic [OW-1:0] occ_r;
    logic [OW-1:0] occ_nxt_s;
    logic          spec_full_r;
    logic          enq_s;
    logic          deq_s;
    logic          drop_s;
    ckpt_t         restore_s;

    // Checkpoint FIFO control; a full FIFO drops its oldest entry to make room.
    always_comb begin
        enq_s           = (push | pop) & ~flush;
        deq_s           = branch_retired & ~flush & (occ_r != {OW{1'b0}});
        drop_s          = enq_s & ~deq_s & (occ_r == OW'(MAX_SPEC));
        occ_nxt_s       = occ_r;
        restore_valid_s = 1'b0;
        restore_s       = ckpt_r[head_r];
        case ({enq_s, deq_s | drop_s})
            2'b10:   occ_nxt_s = occ_r + OW'(1);
            2'b01:   occ_nxt_s = occ_r - OW'(1);
            default: occ_nxt_s = occ_r;
        endcase
        // A retire coinciding with flush consumes the oldest checkpoint first.
        if (branch_retired && (occ_r != {OW{1'b0}})) begin
            restore_valid_s = (occ_r > OW'(1));
            restore_s       = ckpt_r[head_r + SW'(1)];
        end else begin
            restore_valid_s = (occ_r != {OW{1'b0}});
            restore_s       = ckpt_r[head_r];
        end
        restore_valid_s = restore_valid_s & flush;
    end

    assign restore_idx_s = restore_s.idx;
    assign restore_cnt_s = restore_s.cnt;
    assign spec_full     = spec_full_r;

    // Checkpoint storage, pre-op pointer snapshot.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            ckpt_r[tail_r] <= {read_index_r, count_r};
        end
    end

    // Checkpoint FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r      <= {SW{1'b0}};
            tail_r      <= {SW{1'b0}};
            occ_r       <= {OW{1'b0}};
            spec_full_r <= 1'b0;
        end else if (flush) begin
            head_r      <= {SW{1'b0}};
            tail_r      <= {SW{1'b0}};
            occ_r       <= {OW{1'b0}};
            spec_full_r <= 1'b0;
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + SW'(1);
            end
            if (deq_s || drop_s) begin
                head_r <= head_r + SW'(1);
            end
            occ_r       <= occ_nxt_s;
            spec_full_r <= (occ_nxt_s == OW'(MAX_SPEC));
        end
    end
`else
    logic unused_s;

    assign unused_s        = &{1'b0, branch_retired, 1'(MAX_SPEC % 2)};
    assign restore_valid_s = 1'b0;
    assign restore_idx_s   = {IW{1'b0}};
    assign restore_cnt_s   = {CW{1'b0}};
    assign spec_full       = 1'b0;
`endif

    // Next stack pointer/count and RAM write; flush suppresses push/pop.
    always_comb begin
        read_index_nxt_s = read_index_r;
        count_nxt_s      = count_r;
        wr_en_s          = 1'b0;
        wr_idx_s         = read_index_r;
        if (flush) begin
            if (restore_valid_s) begin
                read_index_nxt_s = restore_idx_s;
                count_nxt_s      = restore_cnt_s;
            end else begin
                read_index_nxt_s = read_index_r;
                count_nxt_s      = count_r;
            end
        end else begin
            case ({push, pop})
                2'b10: begin
                    wr_en_s          = 1'b1;
                    wr_idx_s         = read_index_r + IW'(1);
                    read_index_nxt_s = read_index_r + IW'(1);
                    count_nxt_s      = (count_r == CW'(DEPTH)) ? count_r : count_r + CW'(1);
                end
                2'b01: begin
                    if (count_r != {CW{1'b0}}) begin
                        read_index_nxt_s = read_index_r - IW'(1);
                        count_nxt_s      = count_r - CW'(1);
                    end else begin
                        read_index_nxt_s = read_index_r;
                        count_nxt_s      = count_r;
                    end
                end
                2'b11: begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = read_index_r;
                end
                default: begin
                    wr_en_s = 1'b0;
                end
            endcase
        end
    end

    // Stack RAM, intentionally unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            stack_r[wr_idx_s] <= new_addr;
        end
    end

    // Stack pointer and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_index_r <= {IW{1'b0}};
            count_r      <= {CW{1'b0}};
        end else begin
            read_index_r <= read_index_nxt_s;
            count_r      <= count_nxt_s;
        end
    end
endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_return_address_stack;
    localparam int DEPTH    = 8;
    localparam int MAX_SPEC = 4;
`ifdef RAS_CHECKPOINT_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic        pop;
    logic [31:0] new_addr;
    logic [31:0] addr;
    logic        valid;
    logic        branch_retired;
    logic        flush;
    logic        spec_full;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    return_address_stack #(.DEPTH(DEPTH), .MAX_SPEC(MAX_SPEC)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
        .addr(addr), .valid(valid), .branch_retired(branch_retired),
        .flush(flush), .spec_full(spec_full)
    );

    // Reference model: stack slots, top index, depth count, checkpoint list
    typedef struct {int idx; int cnt;} ck_t;
    logic [31:0] m_mem [DEPTH];
    int          m_idx;
    int          m_cnt;
    ck_t         m_q[$];

    function automatic logic [31:0] exp_addr();
        return (m_cnt != 0) ? m_mem[m_idx] : 32'h0;
    endfunction

    function automatic bit exp_full();
        return CK ? (m_q.size() == MAX_SPEC) : 1'b0;
    endfunction

    function automatic void model_update(bit pu, bit po, logic [31:0] a, bit r, bit f);
        ck_t c;
        if (f) begin
            if (CK) begin
                if (r && m_q.size() > 0) void'(m_q.pop_front());
                if (m_q.size() > 0) begin
                    m_idx = m_q[0].idx;
                    m_cnt = m_q[0].cnt;
                end
                m_q.delete();
            end
        end else begin
            if (CK) begin
                if (r && m_q.size() > 0) void'(m_q.pop_front());
                if (pu || po) begin
                    c.idx = m_idx;
                    c.cnt = m_cnt;
                    m_q.push_back(c);
                    if (m_q.size() > MAX_SPEC) void'(m_q.pop_front());
                end
            end
            if (pu && po) begin
                m_mem[m_idx] = a;
            end else if (pu) begin
                m_idx = (m_idx + 1) % DEPTH;
                m_mem[m_idx] = a;
                if (m_cnt < DEPTH) m_cnt++;
            end else if (po && m_cnt > 0) begin
                m_idx = (m_idx + DEPTH - 1) % DEPTH;
                m_cnt--;
            end
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, ".addr"}, addr, exp_addr());
        check({tag, ".valid"}, {31'h0, valid}, {31'h0, (m_cnt != 0)});
        check({tag, ".spec_full"}, {31'h0, spec_full}, {31'h0, exp_full()});
    endtask

    task automatic step(bit pu, bit po, logic [31:0] a, bit r, bit f);
        push = pu; pop = po; new_addr = a; branch_retired = r; flush = f;
        @(posedge clk);
        model_update(pu, po, a, r, f);
        #1;
        push = 1'b0; pop = 1'b0; branch_retired = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; branch_retired = 1'b0; flush = 1'b0; new_addr = 32'h0;
        rst = 1'b1;
        m_idx = 0; m_cnt = 0; m_q.delete();
        #2;
        check("reset.addr", addr, 32'h0);
        check("reset.valid", {31'h0, valid}, 32'h0);
        check("reset.spec_full", {31'h0, spec_full}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {bit pu; bit po; logic [31:0] a; logic [31:0] ea; bit ev;} vec_t;
    vec_t tbl[$];

    function automatic void add(bit pu, bit po, logic [31:0] a, logic [31:0] ea, bit ev);
        vec_t v;
        v.pu = pu; v.po = po; v.a = a; v.ea = ea; v.ev = ev;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        do_reset();

        add(1'b1, 1'b0, 32'h100, 32'h100, 1'b1);
        add(1'b1, 1'b0, 32'h200, 32'h200, 1'b1);
        add(1'b0, 1'b1, 32'h0,   32'h100, 1'b1);
        add(1'b0, 1'b1, 32'h0,   32'h0,   1'b0);
        add(1'b0, 1'b1, 32'h0,   32'h0,   1'b0);
        for (int i = 1; i <= 9; i++) add(1'b1, 1'b0, 32'(i * 16), 32'(i * 16), 1'b1);
        for (int i = 8; i >= 2; i--) add(1'b0, 1'b1, 32'h0, 32'(i * 16), 1'b1);
        add(1'b0, 1'b1, 32'h0,   32'h0,   1'b0);
        add(1'b1, 1'b0, 32'h100, 32'h100, 1'b1);
        add(1'b1, 1'b1, 32'h300, 32'h300, 1'b1);
        add(1'b0, 1'b1, 32'h0,   32'h0,   1'b0);

        foreach (tbl[k]) begin
            step(tbl[k].pu, tbl[k].po, tbl[k].a, 1'b0, 1'b0);
            check($sformatf("tbl%0d.addr", k), addr, tbl[k].ea);
            check($sformatf("tbl%0d.valid", k), {31'h0, valid}, {31'h0, tbl[k].ev});
            check($sformatf("tbl%0d.spec_full", k), {31'h0, spec_full}, {31'h0, exp_full()});
        end

        // Retire, then flush after speculative push/pop
        do_reset();
        step(1'b1, 1'b0, 32'h100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h0,   1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0,   1'b0, 1'b1);
        check("seqA.addr", addr, 32'h100);
        check("seqA.valid", {31'h0, valid}, 32'h1);
        check("seqA.spec_full", {31'h0, spec_full}, 32'h0);

        // Five pushes overflow the checkpoint FIFO
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'(i * 17), 1'b0, 1'b0);
        check("seqB.spec_full", {31'h0, spec_full}, {31'h0, CK});
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("seqB.flush_addr", addr, CK ? 32'h11 : 32'h55);
        check("seqB.flush_full", {31'h0, spec_full}, 32'h0);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        check("seqB.pop_valid", {31'h0, valid}, CK ? 32'h0 : 32'h1);
        check("seqB.pop_addr", addr, CK ? 32'h0 : 32'h44);

        // Flush with push and retire together
        do_reset();
        step(1'b1, 1'b0, 32'h100, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h999, 1'b1, 1'b1);
        check("seqC.addr", addr, CK ? 32'h100 : 32'h200);
        check("seqC.valid", {31'h0, valid}, 32'h1);
        check("seqC.spec_full", {31'h0, spec_full}, 32'h0);

        // Random traffic against the model, with occasional async reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35, $urandom,
                     $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6);
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
